// File: rtl/wash_cycle_controller.sv
// Washing-machine preset store and cycle sequencer.
//
// Holds 2**PRESET_AW programmable presets. Each preset has wash, rinse, spin and cloth fields.
// The selected preset is read out combinationally, and its wash+rinse+spin total is read out
// registered. A start command runs the selected preset as a timed wash -> rinse -> spin
// sequence. Phases with a zero time are skipped. A tick prescaler divides the clock into time
// units. The sequence can be aborted, and it pulses done when it completes.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (clears presets and all sequencing state)
//   wr_en      write wash_in/rinse_in/spin_in/cloth_in into preset sel
//   sel        preset select for write, readout and start
//   wash_in    wash time to store
//   rinse_in   rinse time to store
//   spin_in    spin time to store
//   cloth_in   cloth code to store
//   start      begin running preset sel (ignored while busy)
//   abort      terminate the running cycle without a done pulse
//   wash_out   stored wash time of preset sel (combinational)
//   rinse_out  stored rinse time of preset sel (combinational)
//   spin_out   stored spin time of preset sel (combinational)
//   cloth_out  stored cloth code of preset sel (combinational)
//   total_time registered wash+rinse+spin of preset sel
//   phase      0 idle, 1 wash, 2 rinse, 3 spin
//   remaining  time units left in the running cycle
//   busy       phase != 0
//   done       one-cycle completion pulse
module wash_cycle_controller #(
  parameter int unsigned PRESET_AW = 2,
  parameter int unsigned TIME_W    = 5,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [PRESET_AW-1:0] sel,
  input  logic [TIME_W-1:0]    wash_in,
  input  logic [TIME_W-1:0]    rinse_in,
  input  logic [TIME_W-1:0]    spin_in,
  input  logic [TIME_W-1:0]    cloth_in,
  input  logic                 start,
  input  logic                 abort,
  output logic [TIME_W-1:0]    wash_out,
  output logic [TIME_W-1:0]    rinse_out,
  output logic [TIME_W-1:0]    spin_out,
  output logic [TIME_W-1:0]    cloth_out,
  output logic [TIME_W+1:0]    total_time,
  output logic [1:0]           phase,
  output logic [TIME_W+1:0]    remaining,
  output logic                 busy,
  output logic                 done
);

  localparam int NumPresets = 2 ** PRESET_AW;
  localparam int unsigned SumW  = TIME_W + 2;
  // Keep the prescaler at least one bit wide so TICK_DIV=1 still elaborates cleanly.
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWash  = 2'd1;
  localparam logic [1:0] StRinse = 2'd2;
  localparam logic [1:0] StSpin  = 2'd3;

  // ---------------------------------------------------------------------------
  // Preset storage
  // ---------------------------------------------------------------------------
  logic [TIME_W-1:0] wash_mem_q  [NumPresets];
  logic [TIME_W-1:0] rinse_mem_q [NumPresets];
  logic [TIME_W-1:0] spin_mem_q  [NumPresets];
  logic [TIME_W-1:0] cloth_mem_q [NumPresets];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumPresets; i++) begin
        wash_mem_q[i]  <= '0;
        rinse_mem_q[i] <= '0;
        spin_mem_q[i]  <= '0;
        cloth_mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      wash_mem_q[sel]  <= wash_in;
      rinse_mem_q[sel] <= rinse_in;
      spin_mem_q[sel]  <= spin_in;
      cloth_mem_q[sel] <= cloth_in;
    end
  end

  assign wash_out  = wash_mem_q[sel];
  assign rinse_out = rinse_mem_q[sel];
  assign spin_out  = spin_mem_q[sel];
  assign cloth_out = cloth_mem_q[sel];

  // Widened before adding so that three maximal fields cannot overflow.
  logic [SumW-1:0] sel_sum;
  assign sel_sum = {2'b00, wash_out} + {2'b00, rinse_out} + {2'b00, spin_out};

  logic [SumW-1:0] total_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q <= '0;
    end else begin
      total_q <= sel_sum;
    end
  end

  assign total_time = total_q;

  // ---------------------------------------------------------------------------
  // Cycle sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]        phase_q, phase_d;
  logic [TIME_W-1:0] wash_cnt_q, wash_cnt_d;
  logic [TIME_W-1:0] rinse_cnt_q, rinse_cnt_d;
  logic [TIME_W-1:0] spin_cnt_q, spin_cnt_d;
  logic [SumW-1:0]   remaining_q, remaining_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic              done_q, done_d;
  logic              tick;

  assign tick = (tick_q == TickMax);

  always_comb begin
    phase_d     = phase_q;
    wash_cnt_d  = wash_cnt_q;
    rinse_cnt_d = rinse_cnt_q;
    spin_cnt_d  = spin_cnt_q;
    remaining_d = remaining_q;
    tick_d      = tick_q;
    done_d      = 1'b0;

    if (phase_q == StIdle) begin
      // Abort beats start. The latch reads the pre-write preset because storage updates on
      // this same edge.
      if (start && !abort) begin
        wash_cnt_d  = wash_out;
        rinse_cnt_d = rinse_out;
        spin_cnt_d  = spin_out;
        remaining_d = sel_sum;
        tick_d      = '0;
        if (wash_out != '0) begin
          phase_d = StWash;
        end else if (rinse_out != '0) begin
          phase_d = StRinse;
        end else if (spin_out != '0) begin
          phase_d = StSpin;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (abort) begin
      phase_d     = StIdle;
      remaining_d = '0;
      tick_d      = '0;
    end else begin
      tick_d = tick ? '0 : tick_q + TickW'(1);
      if (tick) begin
        remaining_d = remaining_q - SumW'(1);
        case (phase_q)
          StWash: begin
            wash_cnt_d = wash_cnt_q - TIME_W'(1);
            if (wash_cnt_q == TIME_W'(1)) begin
              if (rinse_cnt_q != '0) begin
                phase_d = StRinse;
              end else if (spin_cnt_q != '0) begin
                phase_d = StSpin;
              end else begin
                phase_d = StIdle;
              end
            end
          end
          StRinse: begin
            rinse_cnt_d = rinse_cnt_q - TIME_W'(1);
            if (rinse_cnt_q == TIME_W'(1)) begin
              phase_d = (spin_cnt_q != '0) ? StSpin : StIdle;
            end
          end
          default: begin
            spin_cnt_d = spin_cnt_q - TIME_W'(1);
            if (spin_cnt_q == TIME_W'(1)) begin
              phase_d = StIdle;
            end
          end
        endcase
        // Only a completed last phase returns to idle along this path.
        if (phase_d == StIdle) begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= StIdle;
      wash_cnt_q  <= '0;
      rinse_cnt_q <= '0;
      spin_cnt_q  <= '0;
      remaining_q <= '0;
      tick_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      wash_cnt_q  <= wash_cnt_d;
      rinse_cnt_q <= rinse_cnt_d;
      spin_cnt_q  <= spin_cnt_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  assign phase     = phase_q;
  assign remaining = remaining_q;
  assign busy      = (phase_q != StIdle);
  assign done      = done_q;

endmodule
